buzz_arbiter: RTL and testbench

- Decides which of four player controllers buzzed first in a round, and holds that result until the CPU clears it.
- Sits between the player-controller GPIO pins and the exmem I/O space.
- Provides the debounced and arbitrated playerInputFlag/firstPlayerFlag that software polls.
- Sequences each round (idle, armed, locked, cooldown) and locks out false starts.

---
 rtl/buzz_arbiter.sv | 159 +++++++++++++++
 tb/tb_buzz_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzz_arbiter.sv
// First-to-buzz arbiter for four player buttons: synchronize, debounce, and lock
// the earliest eligible press until the CPU clears it, then enforce a cooldown.
module buzz_arbiter #(
  parameter int unsigned      CNT_W           = 16,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [CNT_W-1:0] LOCKOUT_CYCLES  = 16'd25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       arm,
  input  logic       clear,
  output logic       playerInputFlag,
  output logic [1:0] firstPlayerFlag,
  output logic [3:0] falseStart,
  output logic [1:0] roundState
);

  localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE_CYCLES - 1'b1;
  localparam logic [CNT_W-1:0] LK_LAST = LOCKOUT_CYCLES - 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    LOCKED   = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  logic [3:0] press;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_player
      logic             sync1_q, sync2_q, deb_dly_q;
      logic             deb_q, deb_d;
      logic             press_q, press_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // The level rises on the edge the counter reaches the threshold and drops
      // on the first low sample, so a held button yields a single press pulse.
      always_comb begin
        cnt_d = '0;
        deb_d = 1'b0;
        if (sync2_q) begin
          cnt_d = (cnt_q == DEBOUNCE_CYCLES) ? cnt_q : cnt_q + 1'b1;
          deb_d = deb_q | (cnt_q == DB_LAST);
        end
        press_d = deb_q & ~deb_dly_q;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1_q   <= 1'b0;
          sync2_q   <= 1'b0;
          cnt_q     <= '0;
          deb_q     <= 1'b0;
          deb_dly_q <= 1'b0;
          press_q   <= 1'b0;
        end else begin
          sync1_q   <= btn[gi];
          sync2_q   <= sync1_q;
          cnt_q     <= cnt_d;
          deb_q     <= deb_d;
          deb_dly_q <= deb_q;
          press_q   <= press_d;
        end
      end

      assign press[gi] = press_q;
    end
  endgenerate

  state_t           state_q, state_d;
  logic             flag_q, flag_d;
  logic [1:0]       winner_q, winner_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       fs_q, fs_d;
  logic [CNT_W-1:0] lock_q, lock_d;
  logic [3:0]       elig;
  logic             found;
  logic [1:0]       pick, idx;

  always_comb begin
    state_d  = state_q;
    flag_d   = flag_q;
    winner_d = winner_q;
    last_d   = last_q;
    fs_d     = fs_q;
    lock_d   = lock_q;
    elig     = press & ~fs_q;
    found    = 1'b0;
    pick     = 2'd0;
    idx      = 2'd0;
    // Round-robin search starting just after the previous winner.
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    case (state_q)
      IDLE: begin
        fs_d = fs_q | press;
        if (!clear && arm) state_d = ARMED;
      end
      ARMED: begin
        if (clear) begin
          state_d = COOLDOWN;
          fs_d    = '0;
          lock_d  = '0;
        end else if (found) begin
          flag_d   = 1'b1;
          winner_d = pick;
          last_d   = pick;
          state_d  = LOCKED;
        end
      end
      LOCKED: begin
        if (clear) begin
          flag_d   = 1'b0;
          winner_d = 2'd0;
          fs_d     = '0;
          lock_d   = '0;
          state_d  = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (lock_q == LK_LAST) state_d = IDLE;
        else                   lock_d  = lock_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      flag_q   <= 1'b0;
      winner_q <= 2'd0;
      last_q   <= 2'd3;
      fs_q     <= '0;
      lock_q   <= '0;
    end else begin
      state_q  <= state_d;
      flag_q   <= flag_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      fs_q     <= fs_d;
      lock_q   <= lock_d;
    end
  end

  assign playerInputFlag = flag_q;
  assign firstPlayerFlag = winner_q;
  assign falseStart      = fs_q;
  assign roundState      = state_q;

endmodule

// File: tb/tb_buzz_arbiter.sv
// Bench for buzz_arbiter: directed round scenarios plus random traffic against a
// run-length/delay-line reference model of the round rules.
module tb_buzz_arbiter;

  localparam int D = 4;
  localparam int L = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = 4'h0;
  logic       arm = 1'b0;
  logic       clear = 1'b0;
  logic       playerInputFlag;
  logic [1:0] firstPlayerFlag;
  logic [3:0] falseStart;
  logic [1:0] roundState;

  int total = 0;
  int bad = 0;

  buzz_arbiter #(
    .CNT_W(16),
    .DEBOUNCE_CYCLES(16'd4),
    .LOCKOUT_CYCLES(16'd8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .arm(arm),
    .clear(clear),
    .playerInputFlag(playerInputFlag),
    .firstPlayerFlag(firstPlayerFlag),
    .falseStart(falseStart),
    .roundState(roundState)
  );

  always #5 clk = ~clk;

  // Reference model: a press is due once a button has D consecutive high samples,
  // and reaches the round logic four edges after the completing sample.
  int         run [4];
  logic [3:0] hist [4];
  int         m_state, m_win, m_last, m_cd;
  logic       m_flag;
  logic [3:0] m_fs;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      run[i]  = 0;
      hist[i] = 4'h0;
    end
    m_state = 0; m_win = 0; m_last = 3; m_cd = 0; m_flag = 1'b0; m_fs = 4'h0;
  endtask

  task automatic model_edge(input logic a, input logic c, input logic [3:0] b);
    logic [3:0] done, eff, elig;
    int w;
    done = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        if (run[i] <= D) run[i]++;
        if (run[i] == D) done[i] = 1'b1;
      end else begin
        run[i] = 0;
      end
    end
    eff = hist[3];
    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = done;
    case (m_state)
      0: begin
        m_fs = m_fs | eff;
        if (!c && a) m_state = 1;
      end
      1: begin
        if (c) begin
          m_state = 3; m_cd = 0; m_fs = 4'h0;
        end else begin
          elig = eff & ~m_fs;
          if (elig != 4'h0) begin
            w = -1;
            for (int k = 1; k <= 4; k++)
              if (w < 0 && elig[(m_last + k) % 4]) w = (m_last + k) % 4;
            m_win = w; m_last = w; m_flag = 1'b1; m_state = 2;
          end
        end
      end
      2: begin
        if (c) begin
          m_flag = 1'b0; m_win = 0; m_fs = 4'h0; m_cd = 0; m_state = 3;
        end
      end
      default: begin
        if (m_cd == L - 1) m_state = 0;
        else m_cd++;
      end
    endcase
  endtask

  function automatic logic [8:0] dut_vec();
    return {playerInputFlag, firstPlayerFlag, falseStart, roundState};
  endfunction

  function automatic logic [8:0] mdl_vec();
    return {m_flag, 2'(m_win), m_fs, 2'(m_state)};
  endfunction

  task automatic tick(input logic a, input logic c, input logic [3:0] b);
    arm = a; clear = c; btn = b;
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge(a, c, b);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    tick(1'b0, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 4'h0);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    total++;
    if (dut_vec() !== 9'h000) begin
      bad++; $display("FAIL reset_hold got=%h want=000", dut_vec());
    end
    rst = 1'b1;
    tick(1'b0, 1'b0, 4'h0);
    total++;
    if (dut_vec() !== 9'h000) begin
      bad++; $display("FAIL reset_release got=%h want=000", dut_vec());
    end
    $display("reset: outputs=%h", dut_vec());
  endtask

  task automatic test_single();
    int n;
    tick(1'b1, 1'b0, 4'h0);
    total++;
    if (roundState !== 2'd1) begin
      bad++; $display("FAIL single_armed got=%0d want=1", roundState);
    end
    for (int k = 1; k <= 7; k++) tick(1'b0, 1'b0, 4'b0100);
    total++;
    if (playerInputFlag !== 1'b0) begin
      bad++; $display("FAIL single_early got=%b want=0", playerInputFlag);
    end
    tick(1'b0, 1'b0, 4'b0100);
    total++;
    if ({playerInputFlag, firstPlayerFlag, roundState} !== {1'b1, 2'd2, 2'd2}) begin
      bad++; $display("FAIL single_win got=%b/%0d/%0d want=1/2/2",
                      playerInputFlag, firstPlayerFlag, roundState);
    end
    tick(1'b0, 1'b1, 4'b0100);
    total++;
    if (dut_vec() !== {1'b0, 2'd0, 4'h0, 2'd3}) begin
      bad++; $display("FAIL single_clear got=%h want=%h", dut_vec(), {1'b0, 2'd0, 4'h0, 2'd3});
    end
    n = 1;
    for (int k = 0; k < 20 && roundState == 2'd3; k++) begin
      tick(1'b0, 1'b0, 4'b0100);
      if (roundState == 2'd3) n++;
    end
    total++;
    if (n != L || roundState !== 2'd0) begin
      bad++; $display("FAIL single_cooldown got=%0d cycles state=%0d want=%0d cycles state=0",
                      n, roundState, L);
    end
    tick(1'b0, 1'b0, 4'h0);
    total++;
    if (dut_vec() !== mdl_vec()) begin
      bad++; $display("FAIL single_model got=%h want=%h", dut_vec(), mdl_vec());
    end
    $display("single: winner=2 cooldown=%0d", n);
  endtask

  task automatic test_tie_rotation();
    int exp_w [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int r = 0; r < 5; r++) begin
      tick(1'b1, 1'b0, 4'b1111);
      for (int k = 0; k < 30 && !playerInputFlag; k++) tick(1'b0, 1'b0, 4'b1111);
      total++;
      if (playerInputFlag !== 1'b1 || firstPlayerFlag !== 2'(exp_w[r])) begin
        bad++; $display("FAIL tie_round%0d got=%b/%0d want=1/%0d",
                        r, playerInputFlag, firstPlayerFlag, exp_w[r]);
      end
      $display("tie: round=%0d winner=%0d", r, firstPlayerFlag);
      tick(1'b0, 1'b1, 4'b1111);
      for (int k = 0; k < 20 && roundState == 2'd3; k++) tick(1'b0, 1'b0, 4'b1111);
      tick(1'b0, 1'b0, 4'h0);
      tick(1'b0, 1'b0, 4'h0);
    end
    total++;
    if (dut_vec() !== mdl_vec()) begin
      bad++; $display("FAIL tie_model got=%h want=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_false_start();
    repeat (6) tick(1'b0, 1'b0, 4'b1000);
    repeat (4) tick(1'b0, 1'b0, 4'h0);
    total++;
    if (falseStart !== 4'b1000 || roundState !== 2'd0) begin
      bad++; $display("FAIL fs_set got=%b/%0d want=1000/0", falseStart, roundState);
    end
    tick(1'b1, 1'b0, 4'h0);
    repeat (10) tick(1'b0, 1'b0, 4'b1000);
    total++;
    if (playerInputFlag !== 1'b0) begin
      bad++; $display("FAIL fs_ignored got=%b want=0", playerInputFlag);
    end
    for (int k = 0; k < 30 && !playerInputFlag; k++) tick(1'b0, 1'b0, 4'b1010);
    total++;
    if ({playerInputFlag, firstPlayerFlag, falseStart} !== {1'b1, 2'd1, 4'b1000}) begin
      bad++; $display("FAIL fs_win got=%b/%0d/%b want=1/1/1000",
                      playerInputFlag, firstPlayerFlag, falseStart);
    end
    tick(1'b0, 1'b1, 4'b1010);
    total++;
    if (falseStart !== 4'h0) begin
      bad++; $display("FAIL fs_clear got=%b want=0000", falseStart);
    end
    for (int k = 0; k < 20 && roundState == 2'd3; k++) tick(1'b0, 1'b0, 4'h0);
    $display("false_start: winner=1");
  endtask

  task automatic test_debounce();
    int rises;
    logic prev;
    tick(1'b1, 1'b0, 4'h0);
    repeat (5) begin
      repeat (3) tick(1'b0, 1'b0, 4'b0001);
      repeat (2) tick(1'b0, 1'b0, 4'h0);
    end
    total++;
    if (playerInputFlag !== 1'b0 || roundState !== 2'd1) begin
      bad++; $display("FAIL glitch got=%b/%0d want=0/1", playerInputFlag, roundState);
    end
    rises = 0;
    prev = playerInputFlag;
    repeat (20) begin
      tick(1'b0, 1'b0, 4'b0001);
      if (playerInputFlag && !prev) rises++;
      prev = playerInputFlag;
    end
    total++;
    if (rises != 1 || firstPlayerFlag !== 2'd0 || roundState !== 2'd2) begin
      bad++; $display("FAIL held_once got=%0d wins p%0d st%0d want=1 wins p0 st2",
                      rises, firstPlayerFlag, roundState);
    end
    tick(1'b0, 1'b1, 4'h0);
    for (int k = 0; k < 20 && roundState == 2'd3; k++) tick(1'b0, 1'b0, 4'h0);
    $display("debounce: wins=%0d", rises);
  endtask

  task automatic test_priority();
    int n;
    tick(1'b1, 1'b0, 4'h0);
    repeat (7) tick(1'b0, 1'b0, 4'b0100);
    tick(1'b0, 1'b1, 4'b0100);
    total++;
    if (roundState !== 2'd3 || playerInputFlag !== 1'b0) begin
      bad++; $display("FAIL abort got=%0d/%b want=3/0", roundState, playerInputFlag);
    end
    for (int k = 0; k < 20 && roundState == 2'd3; k++) tick(1'b0, 1'b0, 4'b0100);
    tick(1'b0, 1'b0, 4'h0);
    tick(1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 30 && !playerInputFlag; k++) tick(1'b0, 1'b0, 4'b0010);
    tick(1'b1, 1'b1, 4'b0010);
    total++;
    if (roundState !== 2'd3 || playerInputFlag !== 1'b0) begin
      bad++; $display("FAIL arm_clear got=%0d/%b want=3/0", roundState, playerInputFlag);
    end
    n = 1;
    for (int k = 0; k < 20 && roundState == 2'd3; k++) begin
      tick(k == 2, 1'b0, 4'b0010);
      if (roundState == 2'd3) n++;
    end
    tick(1'b0, 1'b0, 4'h0);
    total++;
    if (n != L || roundState !== 2'd0) begin
      bad++; $display("FAIL cd_arm got=%0d cycles st%0d want=%0d cycles st0", n, roundState, L);
    end
    total++;
    if (dut_vec() !== mdl_vec()) begin
      bad++; $display("FAIL prio_model got=%h want=%h", dut_vec(), mdl_vec());
    end
    $display("priority: cooldown=%0d", n);
  endtask

  task automatic test_async_reset();
    tick(1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 30 && !playerInputFlag; k++) tick(1'b0, 1'b0, 4'b0100);
    total++;
    if (firstPlayerFlag !== 2'd2 || roundState !== 2'd2) begin
      bad++; $display("FAIL ar_locked got=%0d/%0d want=2/2", firstPlayerFlag, roundState);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (dut_vec() !== 9'h000) begin
      bad++; $display("FAIL ar_immediate got=%h want=000", dut_vec());
    end
    model_reset();
    tick(1'b0, 1'b0, 4'h0);
    rst = 1'b1;
    tick(1'b1, 1'b0, 4'b1111);
    for (int k = 0; k < 30 && !playerInputFlag; k++) tick(1'b0, 1'b0, 4'b1111);
    total++;
    if (playerInputFlag !== 1'b1 || firstPlayerFlag !== 2'd0) begin
      bad++; $display("FAIL ar_tie got=%b/%0d want=1/0", playerInputFlag, firstPlayerFlag);
    end
    tick(1'b0, 1'b1, 4'h0);
    for (int k = 0; k < 20 && roundState == 2'd3; k++) tick(1'b0, 1'b0, 4'h0);
    $display("async_reset: tie winner=%0d", firstPlayerFlag);
  endtask

  task automatic test_random();
    logic [3:0] rb;
    logic a, c;
    int errs;
    rb = 4'h0;
    errs = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9) == 0) rb[i] = ~rb[i];
      a = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 47) == 0);
      tick(a, c, rb);
      total++;
      if (dut_vec() !== mdl_vec()) begin
        bad++; errs++;
        $display("FAIL random_cycle%0d got=%h want=%h", n, dut_vec(), mdl_vec());
      end
    end
    $display("random: 3000 cycles, mismatching=%0d", errs);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_tie_rotation();
    test_false_start();
    test_debounce();
    test_priority();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
